// File: rtl/rx_resp_pkt_arbiter_pkg.sv
// rx_resp_pkt_arbiter_pkg: shared 36-bit stream constants and arbiter state encoding
package rx_resp_pkt_arbiter_pkg;
    localparam int STREAM_W = 36;
    localparam int SOF_BIT  = 32;
    localparam int EOF_BIT  = 33;
    typedef enum logic [1:0] {IDLE = 2'd0, SEND0 = 2'd1, SEND1 = 2'd2} state_e;
    typedef logic [STREAM_W-1:0] beat_t;
endpackage

// File: rtl/rx_resp_pkt_arbiter_sel.sv
// pkt_arb_sel: picks the next packet owner and updates the in1 starvation counter
module pkt_arb_sel
    import rx_resp_pkt_arbiter_pkg::*;
#(
    parameter int MAX_SKIP = 4
) (
    input  logic       cand0_i,
    input  logic       cand1_i,
    input  logic [3:0] skip_i,
    output state_e     sel_o,
    output logic [3:0] skip_o
);
    logic take1;
    always_comb begin
        take1  = cand1_i && (!cand0_i || skip_i >= 4'(MAX_SKIP));
        sel_o  = take1 ? SEND1 : cand0_i ? SEND0 : IDLE;
        skip_o = take1 ? 4'd0 : (cand0_i && cand1_i) ? skip_i + 4'd1 : skip_i;
    end
endmodule

// File: rtl/rx_resp_pkt_arbiter.sv
// rx_resp_pkt_arbiter: packet-atomic merge of response and rx-sample streams with in1 anti-starvation
module rx_resp_pkt_arbiter
    import rx_resp_pkt_arbiter_pkg::*;
#(
    parameter int MAX_SKIP = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic [STREAM_W-1:0] in0_data,
    input  logic                in0_src_rdy,
    output logic                in0_dst_rdy,
    input  logic [STREAM_W-1:0] in1_data,
    input  logic                in1_src_rdy,
    output logic                in1_dst_rdy,
    output logic [STREAM_W-1:0] out_data,
    output logic                out_src_rdy,
    input  logic                out_dst_rdy,
    output logic [1:0]          grant,
    output logic [15:0]         drop_count
);
    state_e      state_q, state_d, sel;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  skip_q, skip_d, skip_sel;
    logic [15:0] drop_q, drop_d;
    logic [16:0] drop_sum;
    logic        rst, idle, s0, s1, cand0, cand1, orph0, orph1, eof0, eof1;

    assign rst   = reset | clear;
    assign idle  = state_q == IDLE;
    assign cand0 = in0_src_rdy & in0_data[SOF_BIT];
    assign cand1 = in1_src_rdy & in1_data[SOF_BIT];
    assign orph0 = in0_src_rdy & ~in0_data[SOF_BIT];
    assign orph1 = in1_src_rdy & ~in1_data[SOF_BIT];
    assign eof0  = in0_src_rdy & out_dst_rdy & in0_data[EOF_BIT];
    assign eof1  = in1_src_rdy & out_dst_rdy & in1_data[EOF_BIT];

    pkt_arb_sel #(.MAX_SKIP(MAX_SKIP)) u_sel (
        .cand0_i(cand0),
        .cand1_i(cand1),
        .skip_i (skip_q),
        .sel_o  (sel),
        .skip_o (skip_sel)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            skip_q  <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            skip_q  <= skip_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d  = idle ? sel
                 : state_q == SEND0 ? (eof0 ? IDLE : SEND0)
                 : state_q == SEND1 ? (eof1 ? IDLE : SEND1) : IDLE;
        skip_d   = idle ? skip_sel : skip_q;
        grant_d  = {state_d == SEND1, state_d == SEND0};
        drop_sum = {1'b0, drop_q} + 17'(idle & orph0) + 17'(idle & orph1);
        drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Reset/clear cycle forces every handshake low so no beat moves while state is abandoned
    always_comb begin
        s0          = (state_q == SEND0) & ~rst;
        s1          = (state_q == SEND1) & ~rst;
        out_src_rdy = s0 ? in0_src_rdy : s1 ? in1_src_rdy : 1'b0;
        out_data    = out_src_rdy ? (s0 ? in0_data : in1_data) : '0;
        in0_dst_rdy = s0 ? out_dst_rdy : idle & ~rst & orph0;
        in1_dst_rdy = s1 ? out_dst_rdy : idle & ~rst & orph1;
    end

    assign grant      = grant_q;
    assign drop_count = drop_q;
endmodule

// File: tb/tb_rx_resp_pkt_arbiter.sv
// tb_rx_resp_pkt_arbiter: idle-decision vector table plus scoreboarded packet scenarios
module tb_rx_resp_pkt_arbiter;
    import rx_resp_pkt_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset, clear;
    beat_t       in0_data, in1_data, out_data;
    logic        in0_src_rdy, in0_dst_rdy, in1_src_rdy, in1_dst_rdy;
    logic        out_src_rdy, out_dst_rdy;
    logic [1:0]  grant;
    logic [15:0] drop_count;

    rx_resp_pkt_arbiter #(.MAX_SKIP(4)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in0_data(in0_data), .in0_src_rdy(in0_src_rdy), .in0_dst_rdy(in0_dst_rdy),
        .in1_data(in1_data), .in1_src_rdy(in1_src_rdy), .in1_dst_rdy(in1_dst_rdy),
        .out_data(out_data), .out_src_rdy(out_src_rdy), .out_dst_rdy(out_dst_rdy),
        .grant(grant), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic v0, s0, v1, s1, d0, d1;
        logic [1:0] g;
        logic [1:0] drop;
    } vec_t;

    int          checks = 0, errors = 0, n;
    beat_t       q0[$], q1[$];
    logic [37:0] sb[$];
    logic        en0 = 1'b1, en1 = 1'b1, no0 = 1'b0;
    vec_t        vt[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        in0_src_rdy = en0 && q0.size() != 0;
        in0_data    = in0_src_rdy ? q0[0] : '0;
        in1_src_rdy = en1 && q1.size() != 0;
        in1_data    = in1_src_rdy ? q1[0] : '0;
    endtask

    task automatic cycle();
        logic x0, x1;
        logic [37:0] e;
        @(negedge clk);
        x0 = in0_src_rdy & in0_dst_rdy;
        x1 = in1_src_rdy & in1_dst_rdy;
        if (no0) chk("no_in0_accept", in0_dst_rdy, 0);
        if (out_src_rdy && out_dst_rdy) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual=%h required=none", out_data);
            end else begin
                e = sb.pop_front();
                chk("out_beat", {grant, out_data}, e);
            end
        end
        @(posedge clk);
        #1;
        if (x0) void'(q0.pop_front());
        if (x1) void'(q1.pop_front());
        drive();
    endtask

    task automatic pkt(input int port, input int len, input logic [7:0] tag);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b = {2'(i), i == len - 1, i == 0, 16'h0, tag, 8'(i)};
            if (port == 0) q0.push_back(b);
            else q1.push_back(b);
            sb.push_back({port == 0 ? 2'b01 : 2'b10, b});
        end
    endtask

    task automatic orph(input int port, input int len);
        for (int i = 0; i < len; i++) begin
            if (port == 0) q0.push_back({4'b0000, 24'hDEAD00, 8'(i)});
            else q1.push_back({4'b0000, 24'hDEAD00, 8'(i)});
        end
    endtask

    task automatic run_sb(input int budget, output int cnt);
        cnt = 0;
        while (sb.size() != 0 && cnt < budget) begin
            cycle();
            cnt++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout actual=%0d_pending required=0", sb.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        sb.delete();
        en0 = 1'b1;
        en1 = 1'b1;
        drive();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        vt[0] = '{0, 0, 0, 0, 0, 0, 2'b00, 2'd0};
        vt[1] = '{1, 0, 0, 0, 1, 0, 2'b00, 2'd1};
        vt[2] = '{0, 0, 1, 0, 0, 1, 2'b00, 2'd1};
        vt[3] = '{1, 0, 1, 0, 1, 1, 2'b00, 2'd2};
        vt[4] = '{1, 1, 0, 0, 0, 0, 2'b01, 2'd0};
        vt[5] = '{0, 0, 1, 1, 0, 0, 2'b10, 2'd0};
        vt[6] = '{1, 1, 1, 1, 0, 0, 2'b01, 2'd0};
        vt[7] = '{1, 1, 1, 0, 0, 1, 2'b01, 2'd1};
        vt[8] = '{1, 0, 1, 1, 1, 0, 2'b10, 2'd1};
        vt[9] = '{0, 1, 0, 1, 0, 0, 2'b00, 2'd0};

        reset = 1'b1;
        clear = 1'b0;
        out_dst_rdy = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", grant, 0);
        chk("rst_drop", drop_count, 0);
        chk("rst_out_src_rdy", out_src_rdy, 0);
        chk("rst_out_data", out_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            in0_src_rdy = vt[i].v0;
            in0_data    = {3'b000, vt[i].s0, 32'h0000_0A00 + 32'(i)};
            in1_src_rdy = vt[i].v1;
            in1_data    = {3'b000, vt[i].s1, 32'h0000_0B00 + 32'(i)};
            clear = 1'b1;
            #1;
            chk("clr_in0_dst_rdy", in0_dst_rdy, 0);
            chk("clr_in1_dst_rdy", in1_dst_rdy, 0);
            chk("clr_out_src_rdy", out_src_rdy, 0);
            @(posedge clk);
            #1;
            clear = 1'b0;
            #1;
            chk("idle_in0_dst_rdy", in0_dst_rdy, vt[i].d0);
            chk("idle_in1_dst_rdy", in1_dst_rdy, vt[i].d1);
            chk("idle_out_src_rdy", out_src_rdy, 0);
            chk("idle_out_data", out_data, 0);
            chk("idle_grant", grant, 0);
            @(posedge clk);
            #1;
            chk("next_grant", grant, vt[i].g);
            chk("drop_after_idle", drop_count, vt[i].drop);
            in0_src_rdy = 1'b0;
            in1_src_rdy = 1'b0;
        end

        // in0-only 3-beat packet: beats in cycles 2-4, IDLE afterwards
        do_reset();
        pkt(0, 3, 8'h25);
        drive();
        run_sb(10, n);
        chk("s25_cycles", n, 4);
        chk("s25_idle_grant", grant, 0);
        chk("s25_idle_out_src_rdy", out_src_rdy, 0);

        // both inputs busy: in0 x4, in1, in0 x4, in1
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) pkt(0, 2, 8'(8'h60 + 8'(r * 4 + k)));
            pkt(1, 2, 8'(8'h70 + 8'(r)));
        end
        drive();
        run_sb(100, n);
        chk("s26_cycles", n, 30);

        // in1 5-beat packet under 1010 backpressure, in0 arrives mid-packet
        do_reset();
        en0 = 1'b0;
        pkt(1, 5, 8'h27);
        pkt(0, 2, 8'h28);
        drive();
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            no0 = sb.size() > 2;
            cycle();
            out_dst_rdy = ~out_dst_rdy;
            en0 = 1'b1;
            drive();
            n++;
        end
        no0 = 1'b0;
        out_dst_rdy = 1'b1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL s27_timeout actual=%0d_pending required=0", sb.size());
        end

        // three orphans on in1 then a real packet
        do_reset();
        orph(1, 3);
        pkt(1, 2, 8'h28);
        drive();
        run_sb(20, n);
        chk("s28_cycles", n, 6);
        chk("s28_drop", drop_count, 3);

        // reset while beat 3 of a 4-beat in0 packet is offered
        do_reset();
        pkt(0, 4, 8'h29);
        void'(sb.pop_back());
        void'(sb.pop_back());
        drive();
        run_sb(10, n);
        chk("s29_pre_cycles", n, 3);
        reset = 1'b1;
        #1;
        chk("s29_rst_out_src_rdy", out_src_rdy, 0);
        chk("s29_rst_in0_dst_rdy", in0_dst_rdy, 0);
        chk("s29_rst_out_data", out_data, 0);
        cycle();
        reset = 1'b0;
        chk("s29_post_drop", drop_count, 0);
        cycle();
        cycle();
        chk("s29_drop", drop_count, 2);
        chk("s29_grant", grant, 0);
        pkt(0, 1, 8'h2A);
        drive();
        run_sb(10, n);
        chk("s29_regrant_cycles", n, 2);

        // single-beat packets: two cycles each
        do_reset();
        for (int k = 0; k < 4; k++) pkt(0, 1, 8'(8'h30 + 8'(k)));
        pkt(1, 1, 8'h40);
        pkt(1, 1, 8'h41);
        drive();
        run_sb(40, n);
        chk("s30_cycles", n, 12);

        // double orphan drops until drop_count saturates
        do_reset();
        in0_src_rdy = 1'b1;
        in0_data    = '0;
        in1_src_rdy = 1'b1;
        in1_data    = '0;
        repeat (32767) @(posedge clk);
        #1;
        chk("drop_near_sat", drop_count, 16'hFFFE);
        @(posedge clk);
        #1;
        chk("drop_sat", drop_count, 16'hFFFF);
        @(posedge clk);
        #1;
        chk("drop_sat_hold", drop_count, 16'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
